// File: rtl/dut_stim_pkg.sv
// rtl/dut_stim_pkg.sv - shared types, LFSR taps and output-fold helper for the stimulus sequencer
package dut_stim_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARMUP = 3'd1,
    RUN    = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int SIG_W = 64;

  // Fibonacci feedback taps (bit indices of the 64-bit register)
  localparam int TAP_A = 63;
  localparam int TAP_B = 62;
  localparam int TAP_C = 60;
  localparam int TAP_D = 59;

  // Widest DUT output bus the fold helper accepts; callers zero-extend into it
  localparam int FOLD_MAX_W  = 1024;
  localparam int FOLD_SLICES = FOLD_MAX_W / SIG_W;

  // XOR of the 64-bit slices of a y_w-bit bus (zero-extended to whole slices)
  function automatic logic [SIG_W-1:0] fold(input logic [FOLD_MAX_W-1:0] y, input int y_w);
    logic [SIG_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < FOLD_SLICES; i++) begin
      if (i * SIG_W < y_w) acc = acc ^ y[i*SIG_W +: SIG_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/stim_lfsr64.sv
// rtl/stim_lfsr64.sv - 64-bit Fibonacci LFSR with seed load and advance enable
module stim_lfsr64
  import dut_stim_pkg::*;
#(
  parameter logic [63:0] SEED = 64'h0000_0000_0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  output logic [63:0] q
);

  // Reseed on reset or load; otherwise shift left with feedback into bit 0 when enabled
  always_ff @(posedge clk) begin
    if (rst || load) begin
      q <= SEED;
    end else if (advance) begin
      q <= {q[62:0], q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D]};
    end
  end

endmodule

// File: rtl/dut_stim_sequencer.sv
// rtl/dut_stim_sequencer.sv - run controller: LFSR stimulus, output signature, start/busy/done (option: DUT_STIM_GOLDEN_CMP_EN)
module dut_stim_sequencer
  import dut_stim_pkg::*;
#(
  parameter int          IN_W  = 52,
  parameter int          Y_W   = 241,
  parameter int          CYC_W = 16,
  parameter logic [63:0] SEED  = 64'h0000_0000_0000_0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CYC_W-1:0] num_cycles,
  input  logic [7:0]       warmup,
  input  logic [Y_W-1:0]   dut_y,
`ifdef DUT_STIM_GOLDEN_CMP_EN
  input  logic [63:0]      expected_sig,
  output logic             mismatch,
`endif
  output logic [IN_W-1:0]  stim,
  output logic             busy,
  output logic             done,
  output logic [63:0]      signature,
  output logic [CYC_W-1:0] cyc_count
);

  state_t           state_q, state_d;
  logic [CYC_W-1:0] num_q;
  logic [7:0]       warm_q;
  logic [7:0]       warm_cnt;
  logic [63:0]      lfsr_q;
  logic             lfsr_unused;
  logic             accept;
  logic [FOLD_MAX_W-1:0] y_ext;
  logic [SIG_W-1:0] sig_d;
`ifdef DUT_STIM_GOLDEN_CMP_EN
  logic [63:0]      exp_q;
`endif

  assign accept      = (state_q == IDLE) && start;
  assign stim        = lfsr_q[IN_W-1:0];
  assign lfsr_unused = ^lfsr_q;

  stim_lfsr64 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .advance ((state_q == WARMUP) || (state_q == RUN)),
    .q       (lfsr_q)
  );

  // Next signature: rotate left by one and absorb the folded DUT output
  always_comb begin
    y_ext = '0;
    y_ext[Y_W-1:0] = dut_y;
    sig_d = {signature[62:0], signature[63]} ^ fold(y_ext, Y_W);
  end

  // Next-state decode; zero warmup or zero run length skips that phase
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (warmup != 8'd0)          state_d = WARMUP;
          else if (num_cycles != '0)   state_d = RUN;
          else                         state_d = FLUSH;
        end
      end
      WARMUP: begin
        if (warm_cnt == warm_q - 8'd1) state_d = (num_q != '0) ? RUN : FLUSH;
      end
      RUN: begin
        if (cyc_count == num_q - CYC_W'(1)) state_d = FLUSH;
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters, signature and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      num_q     <= '0;
      warm_q    <= '0;
      warm_cnt  <= '0;
      cyc_count <= '0;
      signature <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef DUT_STIM_GOLDEN_CMP_EN
      exp_q     <= '0;
      mismatch  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy    <= (state_d == WARMUP) || (state_d == RUN) || (state_d == FLUSH);
      done    <= (state_d == DONE);
      if (accept) begin
        num_q     <= num_cycles;
        warm_q    <= warmup;
        warm_cnt  <= '0;
        cyc_count <= '0;
        signature <= '0;
`ifdef DUT_STIM_GOLDEN_CMP_EN
        exp_q     <= expected_sig;
        mismatch  <= 1'b0;
`endif
      end
      if (state_q == WARMUP) warm_cnt <= warm_cnt + 8'd1;
      if ((state_q == RUN) && (cyc_count != num_q)) cyc_count <= cyc_count + CYC_W'(1);
      if ((state_q == RUN) || (state_q == FLUSH)) signature <= sig_d;
`ifdef DUT_STIM_GOLDEN_CMP_EN
      if (state_q == FLUSH) mismatch <= (sig_d != exp_q);
`endif
    end
  end

endmodule

// File: tb/tb_dut_stim_sequencer.sv
// tb/tb_dut_stim_sequencer.sv - self-checking bench for dut_stim_sequencer (option: DUT_STIM_GOLDEN_CMP_EN)
module tb_dut_stim_sequencer;

  localparam int          IN_W  = 52;
  localparam int          Y_W   = 241;
  localparam int          CYC_W = 16;
  localparam logic [63:0] SEED  = 64'h0000_0000_0000_0001;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CYC_W-1:0] num_cycles;
  logic [7:0]       warmup;
  logic [Y_W-1:0]   dut_y;
  logic [IN_W-1:0]  stim;
  logic             busy;
  logic             done;
  logic [63:0]      signature;
  logic [CYC_W-1:0] cyc_count;
`ifdef DUT_STIM_GOLDEN_CMP_EN
  logic [63:0]      expected_sig;
  logic             mismatch;
`endif

  dut_stim_sequencer #(.IN_W(IN_W), .Y_W(Y_W), .CYC_W(CYC_W), .SEED(SEED)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_cycles (num_cycles),
    .warmup     (warmup),
    .dut_y      (dut_y),
`ifdef DUT_STIM_GOLDEN_CMP_EN
    .expected_sig (expected_sig),
    .mismatch     (mismatch),
`endif
    .stim       (stim),
    .busy       (busy),
    .done       (done),
    .signature  (signature),
    .cyc_count  (cyc_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]       w;
    logic [CYC_W-1:0] n;
    logic [Y_W-1:0]   y;
    logic [63:0]      sig;
    int               lat;
  } vec_t;

  typedef struct {
    logic [63:0]      sig;
    logic [CYC_W-1:0] cyc;
    int               lat;
    int               busy_cycles;
  } exp_t;

  vec_t            vecs[$];
  exp_t            sb[$];
  logic [IN_W-1:0] cap[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Reference: fold by bit position modulo 64, then rotate-and-xor per sample
  function automatic logic [63:0] model_sig(input logic [Y_W-1:0] y, input int samples);
    logic [63:0] f;
    logic [63:0] s;
    f = '0;
    s = '0;
    for (int i = 0; i < Y_W; i++) f[i % 64] = f[i % 64] ^ y[i];
    for (int k = 0; k < samples; k++) s = {s[62:0], s[63]} ^ f;
    return s;
  endfunction

  // One run: expected result pushed at start, popped and compared when done appears
  task automatic run_case(input vec_t v, input string tag);
    exp_t e;
    int   cyc;
    int   busy_cnt;
    bit   got;
    cyc = 0;
    busy_cnt = 0;
    got = 1'b0;
    @(negedge clk);
    warmup     = v.w;
    num_cycles = v.n;
    dut_y      = v.y;
    start      = 1'b1;
    sb.push_back('{v.sig, v.n, v.lat, int'(v.w) + int'(v.n) + 1});
    @(negedge clk);
    start = 1'b0;
`ifdef DUT_STIM_GOLDEN_CMP_EN
    check({tag, " mismatch cleared at start"}, {63'd0, mismatch}, 64'd0);
`endif
    while (!got && cyc < 600) begin
      if (cyc < 4) cap[cyc] = stim;
      if (busy) busy_cnt++;
      if (done) begin
        got = 1'b1;
        e = sb.pop_front();
        check({tag, " signature"}, signature, e.sig);
        check({tag, " cyc_count"}, 64'(cyc_count), 64'(e.cyc));
        check({tag, " done latency"}, 64'(cyc + 1), 64'(e.lat));
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(e.busy_cycles));
`ifdef DUT_STIM_GOLDEN_CMP_EN
        check({tag, " mismatch"}, {63'd0, mismatch}, {63'd0, (expected_sig != e.sig)});
`endif
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!got) check({tag, " done timeout"}, 64'd0, 64'd1);
    @(negedge clk);
    check({tag, " done one pulse"}, {63'd0, done}, 64'd0);
    check({tag, " signature held"}, signature, v.sig);
  endtask

  initial begin
    logic [Y_W-1:0] ry;
    logic [Y_W-1:0] one;
    int             ok;
    one = Y_W'(1);
    ry  = '0;
    for (int i = 0; i < Y_W; i += 32) ry = ry | (Y_W'($urandom) << i);

    vecs.push_back('{8'd0, 16'd3, Y_W'(0),   64'h0000_0000_0000_0000, 5});
    vecs.push_back('{8'd0, 16'd3, one,       64'h0000_0000_0000_000F, 5});
    vecs.push_back('{8'd2, 16'd3, one << 240, 64'h000F_0000_0000_0000, 7});
    vecs.push_back('{8'd0, 16'd0, Y_W'(5),   64'h0000_0000_0000_0005, 2});
    vecs.push_back('{8'd1, 16'd5, ry,        model_sig(ry, 6),        8});

    rst = 1'b1;
    start = 1'b0;
    warmup = '0;
    num_cycles = '0;
    dut_y = '0;
`ifdef DUT_STIM_GOLDEN_CMP_EN
    expected_sig = '0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset signature", signature, 64'd0);
    check("reset cyc_count", 64'(cyc_count), 64'd0);
    check("reset stim", 64'(stim), 64'(SEED[IN_W-1:0]));

    for (int i = 0; i < vecs.size(); i++) begin
`ifdef DUT_STIM_GOLDEN_CMP_EN
      expected_sig = vecs[i].sig;
`endif
      run_case(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        check("vec0 stim run0", 64'(cap[0]), 64'd1);
        check("vec0 stim run1", 64'(cap[1]), 64'd2);
        check("vec0 stim run2", 64'(cap[2]), 64'd4);
      end
      if (i == 2) check("vec2 stim warmup0", 64'(cap[0]), 64'(SEED[IN_W-1:0]));
    end

`ifdef DUT_STIM_GOLDEN_CMP_EN
    expected_sig = 64'hE;
    run_case(vecs[1], "golden wrong");
    repeat (3) @(negedge clk);
    check("mismatch held", {63'd0, mismatch}, 64'd1);
    expected_sig = 64'hF;
    run_case(vecs[1], "golden right");
`endif

    // start held high: DONE ignores it, the following IDLE cycle accepts it
    @(negedge clk);
    warmup = 8'd0;
    num_cycles = 16'd3;
    dut_y = one;
    start = 1'b1;
    ok = 0;
    for (int c = 0; c < 50 && ok == 0; c++) begin
      @(negedge clk);
      if (done) ok = 1;
    end
    check("held start first done", 64'(ok), 64'd1);
    @(negedge clk);
    check("held start DONE->IDLE", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("held start reaccepted", {63'd0, busy}, 64'd1);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid-run signature", signature, 64'h3);
    check("mid-run cyc_count", 64'(cyc_count), 64'd2);

    // reset mid-RUN aborts without a done pulse
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort signature", signature, 64'd0);
    check("abort stim", 64'(stim), 64'(SEED[IN_W-1:0]));
    check("abort cyc_count", 64'(cyc_count), 64'd0);
    ok = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || busy) ok = 1;
    end
    check("abort no done", 64'(ok), 64'd0);
    check("scoreboard empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
